proc_ctrl: RTL and testbench

Run sequencer between the host register file and the iterative arithmetic datapath. It accepts START/ACK/ABORT commands on `proc_cmd` and snapshots the run constants. It issues `niter` single-outstanding requests to the datapath and accumulates each returned value into a 64-bit sum and sum of squares. It reports IDLE/BUSY/COMPLETE/ERROR on `proc_status`; the host side latches results on COMPLETE and answers with ACK.

---
 rtl/proc_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_proc_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_ctrl.sv
// proc_ctrl: run sequencer between the host register file and the iterative
// arithmetic datapath. A START snapshots the run constants. The block then
// issues niter single-outstanding datapath requests and accumulates the sum
// and the sum of squares of the returned values. It reports
// IDLE/BUSY/COMPLETE/ERROR to the host, which answers COMPLETE/ERROR with ACK.
module proc_ctrl #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic [3:0]  proc_cmd,
  input  logic [31:0] niter,
  input  logic [63:0] constK,
  input  logic [63:0] const1,
  input  logic [63:0] const2,
  output logic [3:0]  proc_status,
  output logic [63:0] proc_sum_dout,
  output logic [63:0] proc_pow_sum_dout,
  output logic        dp_req,
  output logic [31:0] dp_idx,
  output logic [63:0] dp_k,
  output logic [63:0] dp_c1,
  output logic [63:0] dp_c2,
  input  logic        dp_ack,
  input  logic [31:0] dp_result
);

  localparam logic [3:0] CMD_START = 4'd1;
  localparam logic [3:0] CMD_ACK   = 4'd2;
  localparam logic [3:0] CMD_ABORT = 4'd3;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_BUSY     = 4'd1;
  localparam logic [3:0] ST_COMPLETE = 4'd2;
  localparam logic [3:0] ST_ERROR    = 4'd3;

  // Watchdog terminal count: reaching it in REQ without an ack ends the run.
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_ACC  = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] niter_q, niter_d;
  logic [31:0] idx_q, idx_d;
  logic [31:0] wd_q, wd_d;
  logic [63:0] sum_q, sum_d;
  logic [63:0] pow_q, pow_d;
  logic [63:0] k_q, k_d;
  logic [63:0] c1_q, c1_d;
  logic [63:0] c2_q, c2_d;
  logic [3:0]  status_q, status_d;
  logic        req_q, req_d;

  logic        is_start;
  logic        is_ack_cmd;
  logic        is_abort;
  logic        wd_expired;
  logic [31:0] idx_inc;
  logic [63:0] result_ext;
  logic [63:0] result_sq;

  assign is_start   = (proc_cmd == CMD_START);
  assign is_ack_cmd = (proc_cmd == CMD_ACK);
  assign is_abort   = (proc_cmd == CMD_ABORT);
  assign wd_expired = (wd_q == WD_LAST);
  assign idx_inc    = idx_q + 32'd1;
  assign result_ext = {32'b0, dp_result};
  assign result_sq  = result_ext * result_ext;

  // State register plus all run registers; reset returns everything to zero.
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      niter_q  <= '0;
      idx_q    <= '0;
      wd_q     <= '0;
      sum_q    <= '0;
      pow_q    <= '0;
      k_q      <= '0;
      c1_q     <= '0;
      c2_q     <= '0;
      status_q <= ST_IDLE;
      req_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      niter_q  <= niter_d;
      idx_q    <= idx_d;
      wd_q     <= wd_d;
      sum_q    <= sum_d;
      pow_q    <= pow_d;
      k_q      <= k_d;
      c1_q     <= c1_d;
      c2_q     <= c2_d;
      status_q <= status_d;
      req_q    <= req_d;
    end
  end

  // Next-state logic; abort beats timeout, which beats a datapath ack.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (is_start) state_d = (niter == 32'd0) ? S_DONE : S_REQ;
      end
      S_REQ: begin
        if (is_abort)        state_d = S_IDLE;
        else if (wd_expired) state_d = S_ERR;
        else if (dp_ack)     state_d = S_ACC;
      end
      S_ACC: begin
        if (is_abort)                state_d = S_IDLE;
        else if (idx_inc == niter_q) state_d = S_DONE;
        else                         state_d = S_REQ;
      end
      S_DONE, S_ERR: begin
        if (is_ack_cmd) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Run datapath: snapshots, iteration index, watchdog and accumulators.
  always_comb begin
    niter_d = niter_q;
    idx_d   = idx_q;
    wd_d    = wd_q;
    sum_d   = sum_q;
    pow_d   = pow_q;
    k_d     = k_q;
    c1_d    = c1_q;
    c2_d    = c2_q;
    case (state_q)
      S_IDLE: begin
        if (is_start) begin
          niter_d = niter;
          k_d     = constK;
          c1_d    = const1;
          c2_d    = const2;
          idx_d   = '0;
          wd_d    = '0;
          sum_d   = '0;
          pow_d   = '0;
        end
      end
      S_REQ: begin
        // An ack that coincides with abort or timeout is dropped.
        if (!is_abort && !wd_expired) begin
          if (dp_ack) begin
            sum_d = sum_q + result_ext;
            pow_d = pow_q + result_sq;
          end else begin
            wd_d = wd_q + 32'd1;
          end
        end
      end
      S_ACC: begin
        if (!is_abort) begin
          idx_d = idx_inc;
          wd_d  = '0;
        end
      end
      default: ;
    endcase
  end

  // Output decode from the next state, so status and dp_req change on the same edge as the state.
  always_comb begin
    status_d = ST_IDLE;
    req_d    = 1'b0;
    case (state_d)
      S_REQ:   begin status_d = ST_BUSY; req_d = 1'b1; end
      S_ACC:   status_d = ST_BUSY;
      S_DONE:  status_d = ST_COMPLETE;
      S_ERR:   status_d = ST_ERROR;
      default: status_d = ST_IDLE;
    endcase
  end

  assign proc_status       = status_q;
  assign dp_req            = req_q;
  assign proc_sum_dout     = sum_q;
  assign proc_pow_sum_dout = pow_q;
  assign dp_idx            = idx_q;
  assign dp_k              = k_q;
  assign dp_c1             = c1_q;
  assign dp_c2             = c2_q;

endmodule

// File: tb/tb_proc_ctrl.sv
// Testbench for proc_ctrl: a directed and randomized run sequence checked
// against a behavioural model of the sums and the handshake timing.
module tb_proc_ctrl;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        RESET;
  logic [3:0]  proc_cmd;
  logic [31:0] niter;
  logic [63:0] constK, const1, const2;
  logic [3:0]  proc_status;
  logic [63:0] proc_sum_dout, proc_pow_sum_dout;
  logic        dp_req;
  logic [31:0] dp_idx;
  logic [63:0] dp_k, dp_c1, dp_c2;
  logic        dp_ack;
  logic [31:0] dp_result;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  // Per-run stimulus: ack delay (in REQ cycles) and result for each iteration.
  int          dly_a [16];
  logic [31:0] res_a [16];

  proc_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .RESET(RESET), .proc_cmd(proc_cmd), .niter(niter),
    .constK(constK), .const1(const1), .const2(const2),
    .proc_status(proc_status), .proc_sum_dout(proc_sum_dout),
    .proc_pow_sum_dout(proc_pow_sum_dout), .dp_req(dp_req), .dp_idx(dp_idx),
    .dp_k(dp_k), .dp_c1(dp_c1), .dp_c2(dp_c2),
    .dp_ack(dp_ack), .dp_result(dp_result)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Square of a 32-bit result as a 64-bit quantity.
  function automatic logic [63:0] sq64(input logic [31:0] r);
    longint unsigned v;
    v = longint'(r);
    return v * v;
  endfunction

  // One complete run: START, serve the requests with the tabled delays and
  // results, check every step against the model sums, end in COMPLETE.
  task automatic do_run(input int n, input bit busy_start,
                        output logic [63:0] s, output logic [63:0] p);
    logic [63:0] k, c1, c2, ms, mp;
    k  = {$urandom, $urandom};
    c1 = {$urandom, $urandom};
    c2 = {$urandom, $urandom};
    ms = 64'd0;
    mp = 64'd0;
    niter = n; constK = k; const1 = c1; const2 = c2;
    proc_cmd = 4'd1;
    tick;
    proc_cmd = 4'd0;
    vec_cnt++;
    if (proc_status !== ((n == 0) ? 4'd2 : 4'd1) || proc_sum_dout !== 64'd0 || proc_pow_sum_dout !== 64'd0)
      begin miss_cnt++; $display("FAIL start n=%0d: status=%0d sum=%h pow=%h, want status=%0d sums 0", n, proc_status, proc_sum_dout, proc_pow_sum_dout, (n == 0) ? 2 : 1); end
    for (int i = 0; i < n; i++) begin
      for (int w = 0; w < dly_a[i]; w++) tick;
      vec_cnt++;
      if (dp_req !== 1'b1 || dp_idx !== 32'(i) || dp_k !== k || dp_c1 !== c1 || dp_c2 !== c2 || proc_status !== 4'd1)
        begin miss_cnt++; $display("FAIL req i=%0d: req=%b idx=%0d k=%h c1=%h c2=%h st=%0d, want req=1 idx=%0d k=%h c1=%h c2=%h st=1", i, dp_req, dp_idx, dp_k, dp_c1, dp_c2, proc_status, i, k, c1, c2); end
      if (busy_start && i == 1) begin
        proc_cmd = 4'd1; niter = 32'(n + 5); constK = ~k;
      end
      dp_ack = 1'b1; dp_result = res_a[i];
      tick;
      dp_ack = 1'b0; proc_cmd = 4'd0;
      ms = ms + {32'd0, res_a[i]};
      mp = mp + sq64(res_a[i]);
      vec_cnt++;
      if (dp_req !== 1'b0 || proc_status !== 4'd1 || proc_sum_dout !== ms || proc_pow_sum_dout !== mp)
        begin miss_cnt++; $display("FAIL acc i=%0d: req=%b st=%0d sum=%h pow=%h, want req=0 st=1 sum=%h pow=%h", i, dp_req, proc_status, proc_sum_dout, proc_pow_sum_dout, ms, mp); end
      tick;
    end
    vec_cnt++;
    if (proc_status !== 4'd2 || dp_req !== 1'b0 || proc_sum_dout !== ms || proc_pow_sum_dout !== mp || dp_k !== k)
      begin miss_cnt++; $display("FAIL done n=%0d: st=%0d req=%b sum=%h pow=%h k=%h, want st=2 req=0 sum=%h pow=%h k=%h", n, proc_status, dp_req, proc_sum_dout, proc_pow_sum_dout, dp_k, ms, mp, k); end
    $display("run n=%0d sum=%h pow=%h", n, ms, mp);
    s = ms;
    p = mp;
  endtask

  // Host ACK from COMPLETE/ERROR: back to IDLE with the sums held.
  task automatic host_ack(input logic [63:0] s, input logic [63:0] p);
    proc_cmd = 4'd2;
    tick;
    proc_cmd = 4'd0;
    vec_cnt++;
    if (proc_status !== 4'd0 || proc_sum_dout !== s || proc_pow_sum_dout !== p)
      begin miss_cnt++; $display("FAIL host_ack: st=%0d sum=%h pow=%h, want st=0 sum=%h pow=%h", proc_status, proc_sum_dout, proc_pow_sum_dout, s, p); end
  endtask

  task automatic check_zero(input string tag);
    vec_cnt++;
    if (proc_status !== 4'd0 || proc_sum_dout !== 64'd0 || proc_pow_sum_dout !== 64'd0 || dp_req !== 1'b0 ||
        dp_idx !== 32'd0 || dp_k !== 64'd0 || dp_c1 !== 64'd0 || dp_c2 !== 64'd0)
      begin miss_cnt++; $display("FAIL %s: st=%0d sum=%h pow=%h req=%b idx=%0d k=%h, want all zero", tag, proc_status, proc_sum_dout, proc_pow_sum_dout, dp_req, dp_idx, dp_k); end
    $display("%s checked", tag);
  endtask

  task automatic test_reset;
    RESET = 1'b1;
    tick; tick;
    RESET = 1'b0;
    check_zero("reset");
  endtask

  task automatic test_basic;
    logic [63:0] s, p;
    dly_a[0] = 0; dly_a[1] = 0; dly_a[2] = 0;
    res_a[0] = 32'd2; res_a[1] = 32'd3; res_a[2] = 32'd4;
    do_run(3, 1'b0, s, p);
    vec_cnt++;
    if (s !== 64'd9 || p !== 64'd29)
      begin miss_cnt++; $display("FAIL basic_sums: sum=%0d pow=%0d, want 9 29", s, p); end
    host_ack(64'd9, 64'd29);
  endtask

  task automatic test_zero_iter;
    logic [63:0] s, p;
    do_run(0, 1'b0, s, p);
    host_ack(64'd0, 64'd0);
  endtask

  task automatic test_wide;
    logic [63:0] s, p;
    dly_a[0] = 5; dly_a[1] = 5;
    res_a[0] = 32'hFFFF_FFFF; res_a[1] = 32'hFFFF_FFFF;
    do_run(2, 1'b0, s, p);
    vec_cnt++;
    if (s !== 64'h1_FFFF_FFFE || p !== 64'hFFFF_FFFC_0000_0002)
      begin miss_cnt++; $display("FAIL wide_sums: sum=%h pow=%h, want 1fffffffe fffffffc00000002", s, p); end
    host_ack(s, p);
  endtask

  task automatic test_random;
    logic [63:0] s, p;
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 7);
      for (int i = 0; i < n; i++) begin
        dly_a[i] = $urandom_range(0, 5);
        res_a[i] = $urandom;
      end
      do_run(n, 1'b0, s, p);
      host_ack(s, p);
    end
  endtask

  task automatic test_timeout;
    logic [31:0] r;
    int cnt;
    r = $urandom;
    niter = 32'd4; constK = 64'd1; const1 = 64'd2; const2 = 64'd3;
    proc_cmd = 4'd1;
    tick;
    proc_cmd = 4'd0;
    dp_ack = 1'b1; dp_result = r;
    tick;
    dp_ack = 1'b0;
    tick;
    cnt = 0;
    while (proc_status !== 4'd3 && cnt < 30) begin
      tick;
      cnt++;
    end
    vec_cnt++;
    if (cnt !== TO || dp_req !== 1'b0 || proc_sum_dout !== {32'd0, r} || proc_pow_sum_dout !== sq64(r))
      begin miss_cnt++; $display("FAIL timeout: cycles=%0d req=%b sum=%h pow=%h, want cycles=%0d req=0 sum=%h pow=%h", cnt, dp_req, proc_sum_dout, proc_pow_sum_dout, TO, {32'd0, r}, sq64(r)); end
    $display("timeout after %0d cycles", cnt);
    host_ack({32'd0, r}, sq64(r));
  endtask

  task automatic test_abort;
    logic [31:0] r;
    logic [63:0] s, p;
    r = $urandom;
    niter = 32'd5;
    proc_cmd = 4'd1;
    tick;
    proc_cmd = 4'd0;
    dp_ack = 1'b1; dp_result = r;
    tick;
    dp_ack = 1'b0;
    tick;
    proc_cmd = 4'd3; dp_ack = 1'b1; dp_result = 32'd7;
    tick;
    proc_cmd = 4'd0; dp_ack = 1'b0;
    vec_cnt++;
    if (proc_status !== 4'd0 || dp_req !== 1'b0 || proc_sum_dout !== {32'd0, r} || proc_pow_sum_dout !== sq64(r))
      begin miss_cnt++; $display("FAIL abort: st=%0d req=%b sum=%h pow=%h, want st=0 req=0 sum=%h pow=%h", proc_status, dp_req, proc_sum_dout, proc_pow_sum_dout, {32'd0, r}, sq64(r)); end
    // ACK and ABORT in IDLE do nothing.
    proc_cmd = 4'd2; tick;
    proc_cmd = 4'd3; tick;
    proc_cmd = 4'd0;
    vec_cnt++;
    if (proc_status !== 4'd0 || proc_sum_dout !== {32'd0, r})
      begin miss_cnt++; $display("FAIL idle_cmds: st=%0d sum=%h, want st=0 sum=%h", proc_status, proc_sum_dout, {32'd0, r}); end
    for (int i = 0; i < 3; i++) begin dly_a[i] = $urandom_range(0, 3); res_a[i] = $urandom; end
    do_run(3, 1'b0, s, p);
    host_ack(s, p);
  endtask

  task automatic test_start_busy;
    logic [63:0] s, p;
    for (int i = 0; i < 4; i++) begin dly_a[i] = $urandom_range(0, 2); res_a[i] = $urandom; end
    do_run(4, 1'b1, s, p);
    host_ack(s, p);
  endtask

  task automatic test_reset_mid;
    niter = 32'd6; constK = {$urandom, $urandom};
    proc_cmd = 4'd1;
    tick;
    proc_cmd = 4'd0;
    dp_ack = 1'b1; dp_result = $urandom;
    tick;
    dp_ack = 1'b0;
    tick;
    RESET = 1'b1;
    tick;
    check_zero("reset_mid");
    RESET = 1'b0;
    tick;
    check_zero("reset_mid_idle");
  endtask

  initial begin
    RESET = 1'b1; proc_cmd = 4'd0; niter = '0;
    constK = '0; const1 = '0; const2 = '0;
    dp_ack = 1'b0; dp_result = '0;
    test_reset;
    test_basic;
    test_zero_iter;
    test_wide;
    test_random;
    test_timeout;
    test_abort;
    test_start_busy;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
